// File: rtl/uart_pkg.sv
// Shared UART types and defaults, used by both the transmit and receive paths.
package uart_pkg;

    typedef logic [15:0] timer_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam timer_t BIT_TIME_DEFAULT   = timer_t'(434);
    localparam int     DATA_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between the command logic (master) and the UART transmitter (slave).
interface uart_tx_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) ();

    logic                  tx_valid;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_ready;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);

endinterface

// File: rtl/bit_timer.sv
// Free-running bit-period counter: counts 0..limit-1, flags the last cycle with bit_end.
module bit_timer
    import uart_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   clear,
    input  timer_t limit,
    output logic   bit_end
);

    timer_t count;

    assign bit_end = (count == limit - timer_t'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || bit_end) begin
            count <= '0;
        end else begin
            count <= count + timer_t'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first data, optional even parity, 1 or 2 stop bits.
//
// state  | meaning
// IDLE   | line high, ready for a byte
// START  | start bit (line low)
// DATA   | data bit shift[0] on the line
// PARITY | even-parity bit
// STOP   | stop bit(s), line high
module uart_tx
    import uart_pkg::*;
#(
    parameter int     DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter timer_t BIT_TIME   = BIT_TIME_DEFAULT,
    parameter int     PARITY_EN  = 0,
    parameter int     STOP_BITS  = 1
) (
    input  logic      clk,
    input  logic      rst,
    uart_tx_if.slave  bus,
    output logic      tx_busy,
    output logic      tx_done,
    output logic      tx
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    tx_state_t             state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  parity_q, parity_d;
    logic                  stop_q, stop_d;
    logic                  tx_d, done_d, ready_q, ready_d;
    logic                  bit_end, timer_clear;

    bit_timer u_bit_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (timer_clear),
        .limit  (BIT_TIME),
        .bit_end(bit_end)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        parity_d = parity_q;
        stop_d   = stop_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.tx_valid && ready_q) begin
                    shift_d  = bus.tx_data;
                    parity_d = ^bus.tx_data;
                    idx_d    = '0;
                    stop_d   = 1'b0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (idx_q == IDX_W'(DATA_WIDTH - 1)) begin
                        state_d = (PARITY_EN != 0) ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (stop_q != 1'(STOP_BITS - 1)) begin
                        stop_d = 1'b1;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so tx comes straight off a flop.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = parity_d;
            default: tx_d = 1'b1;
        endcase
    end

    assign ready_d     = (state_d == IDLE);
    assign timer_clear = (state_q == IDLE) || (state_d != state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            idx_q    <= '0;
            parity_q <= 1'b0;
            stop_q   <= 1'b0;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            ready_q  <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            parity_q <= parity_d;
            stop_q   <= stop_d;
            tx       <= tx_d;
            tx_done  <= done_d;
            ready_q  <= ready_d;
            tx_busy  <= !ready_d;
        end
    end

    assign bus.tx_ready = ready_q;

endmodule
